// File: rtl/rf_write_buffer_if.sv
// Handshake/bus bundle for rf_write_buffer: producer push, regfile drain,
// bypass lookups, flush control and occupancy.
interface rf_write_buffer_if #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;
    logic          rf_ready;
    logic [AW-1:0] lk_addr1;
    logic          lk_hit1;
    logic [DW-1:0] lk_data1;
    logic [AW-1:0] lk_addr2;
    logic          lk_hit2;
    logic [DW-1:0] lk_data2;
    logic          flush_req;
    logic          flush_done;
    logic [CW-1:0] count;

    modport master (
        output in_valid, in_addr, in_data, rf_ready,
        output lk_addr1, lk_addr2, flush_req,
        input  in_ready, rf_we, rf_wa, rf_wd,
        input  lk_hit1, lk_data1, lk_hit2, lk_data2,
        input  flush_done, count
    );

    modport slave (
        input  in_valid, in_addr, in_data, rf_ready,
        input  lk_addr1, lk_addr2, flush_req,
        output in_ready, rf_we, rf_wa, rf_wd,
        output lk_hit1, lk_data1, lk_hit2, lk_data2,
        output flush_done, count
    );
endinterface

// File: rtl/rf_write_buffer.sv
// FIFO writeback buffer in front of the regfile write port with bypass lookups
// and a flush FSM. Define WB_COALESCE_EN to merge writes to a pending address.
module rf_write_buffer #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 4
) (
    input logic        clk,
    input logic        rst_n,
    rf_write_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          in_ready;
    logic          push;
    logic          pop;
    logic          merge;
    logic          alloc;
    logic [PW-1:0] merge_idx;
    logic          hit1, hit2;
    logic [DW-1:0] dat1, dat2;
    logic          done;

    assign in_ready = (cnt_q < FULL) && (state_q == RUN);
    assign push     = bus.in_valid && in_ready;
    assign pop      = (cnt_q != '0) && bus.rf_ready;
    assign alloc    = push && (bus.in_addr != '0) && !merge;

    always_comb begin
        merge     = 1'b0;
        merge_idx = wr_q;
`ifdef WB_COALESCE_EN
        // The head leaving this edge cannot absorb the write.
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < cnt_q) && !(k == 0 && pop) &&
                (addr_q[rd_q + PW'(k)] == bus.in_addr)) begin
                merge     = 1'b1;
                merge_idx = rd_q + PW'(k);
            end
        end
`endif
    end

    always_comb begin
        cnt_d = cnt_q;
        if (alloc && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!alloc && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
        rd_d = pop   ? rd_q + 1'b1 : rd_q;
        wr_d = alloc ? wr_q + 1'b1 : wr_q;
    end

    // Oldest to youngest, so the last match wins.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        dat1 = '0;
        dat2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < cnt_q) begin
                if (bus.lk_addr1 != '0 &&
                    addr_q[rd_q + PW'(k)] == bus.lk_addr1) begin
                    hit1 = 1'b1;
                    dat1 = data_q[rd_q + PW'(k)];
                end
                if (bus.lk_addr2 != '0 &&
                    addr_q[rd_q + PW'(k)] == bus.lk_addr2) begin
                    hit2 = 1'b1;
                    dat2 = data_q[rd_q + PW'(k)];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        unique case (state_q)
            RUN: begin
                if (bus.flush_req) begin
                    state_d = (cnt_d == '0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Payload is qualified by the count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (alloc) begin
            addr_q[wr_q] <= bus.in_addr;
            data_q[wr_q] <= bus.in_data;
        end else if (push && merge) begin
            data_q[merge_idx] <= bus.in_data;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.rf_we      = (cnt_q != '0);
    assign bus.rf_wa      = addr_q[rd_q];
    assign bus.rf_wd      = data_q[rd_q];
    assign bus.lk_hit1    = hit1;
    assign bus.lk_data1   = dat1;
    assign bus.lk_hit2    = hit2;
    assign bus.lk_data2   = dat2;
    assign bus.flush_done = done;
    assign bus.count      = cnt_q;
endmodule

// File: tb/tb_rf_write_buffer.sv
// Directed vector table plus hand-written duplicate-address and
// mid-cycle reset sequences for rf_write_buffer.
module tb_rf_write_buffer;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nchk = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    rf_write_buffer_if #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) bus ();

    rf_write_buffer #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        iv;
        logic [4:0]  ia;
        logic [31:0] id;
        logic        rr;
        logic [4:0]  l1;
        logic [4:0]  l2;
        logic        fr;
        logic        e_rdy;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_h1;
        logic [31:0] e_d1;
        logic        e_h2;
        logic [31:0] e_d2;
        logic [2:0]  e_cnt;
        logic        e_fd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic iv, input logic [4:0] ia, input logic [31:0] id,
        input logic rr, input logic [4:0] l1, input logic [4:0] l2,
        input logic fr, input logic rdy, input logic we,
        input logic [4:0] wa, input logic [31:0] wd,
        input logic h1, input logic [31:0] d1,
        input logic h2, input logic [31:0] d2,
        input logic [2:0] cnt, input logic fd);
        vec_t v;
        v.iv = iv; v.ia = ia; v.id = id; v.rr = rr;
        v.l1 = l1; v.l2 = l2; v.fr = fr;
        v.e_rdy = rdy; v.e_we = we; v.e_wa = wa; v.e_wd = wd;
        v.e_h1 = h1; v.e_d1 = d1; v.e_h2 = h2; v.e_d2 = d2;
        v.e_cnt = cnt; v.e_fd = fd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [4:0] ia,
                         input logic [31:0] id, input logic rr,
                         input logic [4:0] l1, input logic [4:0] l2,
                         input logic fr);
        bus.in_valid  = iv;
        bus.in_addr   = ia;
        bus.in_data   = id;
        bus.rf_ready  = rr;
        bus.lk_addr1  = l1;
        bus.lk_addr2  = l2;
        bus.flush_req = fr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dup_seq(input logic [4:0] a, input logic [31:0] d1,
                           input logic [31:0] d2);
        drive(1, a, d1, 0, 0, 0, 0);
        tick();
        drive(1, a, d2, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, a, 0, 0);
        @(negedge clk);
`ifdef WB_COALESCE_EN
        chk("dup cnt", 32'(bus.count), 32'd1);
        chk("dup head wd", bus.rf_wd, d2);
`else
        chk("dup cnt", 32'(bus.count), 32'd2);
        chk("dup head wd", bus.rf_wd, d1);
`endif
        chk("dup hit1", 32'(bus.lk_hit1), 32'd1);
        chk("dup data1 youngest", bus.lk_data1, d2);
        chk("dup head wa", 32'(bus.rf_wa), 32'(a));
        tick();
        drive(0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        chk("dup drain1 we", 32'(bus.rf_we), 32'd1);
        chk("dup drain1 wa", 32'(bus.rf_wa), 32'(a));
`ifdef WB_COALESCE_EN
        chk("dup drain1 wd", bus.rf_wd, d2);
        tick();
        @(negedge clk);
        chk("dup drain2 we", 32'(bus.rf_we), 32'd0);
`else
        chk("dup drain1 wd", bus.rf_wd, d1);
        tick();
        @(negedge clk);
        chk("dup drain2 we", 32'(bus.rf_we), 32'd1);
        chk("dup drain2 wa", 32'(bus.rf_wa), 32'(a));
        chk("dup drain2 wd", bus.rf_wd, d2);
        tick();
        @(negedge clk);
        chk("dup drain3 we", 32'(bus.rf_we), 32'd0);
`endif
        chk("dup empty cnt", 32'(bus.count), 32'd0);
        tick();
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);

        // test 1: single write
        tbl.push_back(mk(1,3,32'hAAAA0001,1,0,0,0, 1,0,0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0,0,0,1,0,0,0, 1,1,3,32'hAAAA0001, 0,0,0,0, 1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 1,0,0,0, 0,0,0,0, 0,0));
        // test 2: fill, backpressure, in-order drain with wrap
        tbl.push_back(mk(1,1,32'h101,0,0,0,0, 1,0,0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(1,2,32'h102,0,0,0,0, 1,1,1,32'h101, 0,0,0,0, 1,0));
        tbl.push_back(mk(1,3,32'h103,0,0,0,0, 1,1,1,32'h101, 0,0,0,0, 2,0));
        tbl.push_back(mk(1,4,32'h104,0,0,0,0, 1,1,1,32'h101, 0,0,0,0, 3,0));
        tbl.push_back(mk(1,5,32'h105,0,0,0,0, 0,1,1,32'h101, 0,0,0,0, 4,0));
        tbl.push_back(mk(1,5,32'h105,1,3,4,0, 0,1,1,32'h101,
                         1,32'h103,1,32'h104, 4,0));
        tbl.push_back(mk(1,5,32'h105,1,0,0,0, 1,1,2,32'h102, 0,0,0,0, 3,0));
        tbl.push_back(mk(0,0,0,1,0,0,0, 1,1,3,32'h103, 0,0,0,0, 3,0));
        tbl.push_back(mk(0,0,0,1,0,0,0, 1,1,4,32'h104, 0,0,0,0, 2,0));
        tbl.push_back(mk(0,0,0,1,5,1,0, 1,1,5,32'h105, 1,32'h105,0,0, 1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 1,0,0,0, 0,0,0,0, 0,0));
        // lookups, addr-0 push, in-flight write invisible
        tbl.push_back(mk(1,6,32'h66,0,6,0,0, 1,0,0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(1,0,32'hFF,0,6,6,0, 1,1,6,32'h66,
                         1,32'h66,1,32'h66, 1,0));
        tbl.push_back(mk(1,9,32'h99,0,0,9,0, 1,1,6,32'h66, 0,0,0,0, 1,0));
        tbl.push_back(mk(0,0,0,0,9,6,0, 1,1,6,32'h66,
                         1,32'h99,1,32'h66, 2,0));
        // test 4: flush with two entries, pushes blocked while draining
        tbl.push_back(mk(0,0,0,1,0,0,1, 1,1,6,32'h66, 0,0,0,0, 2,0));
        tbl.push_back(mk(1,8,32'h88,1,0,0,0, 0,1,9,32'h99, 0,0,0,0, 1,0));
        tbl.push_back(mk(1,8,32'h88,1,0,0,0, 0,0,0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(1,8,32'h88,1,0,0,0, 0,0,0,0, 0,0,0,0, 0,1));
        tbl.push_back(mk(0,0,0,1,0,0,0, 1,0,0,0, 0,0,0,0, 0,0));
        // flush when empty; flush_req ignored in DONE
        tbl.push_back(mk(0,0,0,1,0,0,1, 1,0,0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0,0,0,1,0,0,1, 0,0,0,0, 0,0,0,0, 0,1));
        tbl.push_back(mk(0,0,0,1,0,0,0, 1,0,0,0, 0,0,0,0, 0,0));
        // flush coincident with a push into an empty buffer
        tbl.push_back(mk(1,10,32'hA,0,0,0,1, 1,0,0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,1,10,32'hA, 0,0,0,0, 1,0));
        tbl.push_back(mk(0,0,0,1,0,0,0, 0,1,10,32'hA, 0,0,0,0, 1,0));
        tbl.push_back(mk(0,0,0,1,0,0,0, 0,0,0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0,0,0,1,0,0,0, 0,0,0,0, 0,0,0,0, 0,1));
        tbl.push_back(mk(0,0,0,1,0,0,0, 1,0,0,0, 0,0,0,0, 0,0));

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].iv, tbl[i].ia, tbl[i].id, tbl[i].rr,
                  tbl[i].l1, tbl[i].l2, tbl[i].fr);
            @(negedge clk);
            chk($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("v%0d rf_we", i), 32'(bus.rf_we), 32'(tbl[i].e_we));
            chk($sformatf("v%0d count", i), 32'(bus.count), 32'(tbl[i].e_cnt));
            chk($sformatf("v%0d flush_done", i), 32'(bus.flush_done), 32'(tbl[i].e_fd));
            chk($sformatf("v%0d lk_hit1", i), 32'(bus.lk_hit1), 32'(tbl[i].e_h1));
            chk($sformatf("v%0d lk_hit2", i), 32'(bus.lk_hit2), 32'(tbl[i].e_h2));
            if (tbl[i].e_we) begin
                chk($sformatf("v%0d rf_wa", i), 32'(bus.rf_wa), 32'(tbl[i].e_wa));
                chk($sformatf("v%0d rf_wd", i), bus.rf_wd, tbl[i].e_wd);
            end
            if (tbl[i].e_h1) begin
                chk($sformatf("v%0d lk_data1", i), bus.lk_data1, tbl[i].e_d1);
            end
            if (tbl[i].e_h2) begin
                chk($sformatf("v%0d lk_data2", i), bus.lk_data2, tbl[i].e_d2);
            end
            tick();
        end

        // tests 3 and 6: duplicate addresses
        dup_seq(5'd5, 32'h11, 32'h22);
        dup_seq(5'd7, 32'h1, 32'h2);

        // test 5: asynchronous reset with three pending entries
        drive(1, 11, 32'hB1, 0, 0, 0, 0);
        tick();
        drive(1, 12, 32'hB2, 0, 0, 0, 0);
        tick();
        drive(1, 13, 32'hB3, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 11, 0, 0);
        @(negedge clk);
        chk("rst pre cnt", 32'(bus.count), 32'd3);
        chk("rst pre we", 32'(bus.rf_we), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst async we", 32'(bus.rf_we), 32'd0);
        chk("rst async cnt", 32'(bus.count), 32'd0);
        chk("rst async hit1", 32'(bus.lk_hit1), 32'd0);
        chk("rst async done", 32'(bus.flush_done), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(0, 0, 0, 1, 11, 0, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("post rst%0d we", c), 32'(bus.rf_we), 32'd0);
            chk($sformatf("post rst%0d rdy", c), 32'(bus.in_ready), 32'd1);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
